// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_pkg: slot-entry control typedef and legal parameter ranges.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int c_DEPTH_MIN    = 2;
  localparam int c_DEPTH_MAX    = 6;
  localparam int c_LOAD_LAT_MIN = 1;

  // Data and dest widths are parameters of the unit, so only the flags live here.
  typedef struct packed {
    logic valid;
    logic we;
    logic load;
    logic ready;
  } slotCtrl_t;

  function automatic bit paramsLegal(input int depth, input int loadLat);
    return (depth >= c_DEPTH_MIN) && (depth <= c_DEPTH_MAX) &&
           (loadLat >= c_LOAD_LAT_MIN) && (loadLat <= depth - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_slot.sv
// +----------------------------------------------------------------------------+
// | hazard_slot: one in-flight pipeline slot with capture/advance/kill.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_slot
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4,
  parameter bit CAPTURE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               kill,
  input  slotCtrl_t          inCtrl,
  input  logic [RADDR_W-1:0] inDest,
  input  logic [DATA_W-1:0]  inData,
  input  logic [DATA_W-1:0]  memRdata,
  output slotCtrl_t          ctrl,
  output logic [RADDR_W-1:0] dest,
  output logic [DATA_W-1:0]  data
);

  slotCtrl_t          r_ctrl;
  logic [RADDR_W-1:0] r_dest;
  logic [DATA_W-1:0]  r_data;
  logic               w_capture;

  // Only the slot just past the memory stage latches read data for a pending load.
  assign w_capture = CAPTURE && inCtrl.valid && inCtrl.load && !inCtrl.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_dest <= '0;
      r_data <= '0;
    end else if (kill || !inCtrl.valid) begin
      r_ctrl <= '0;
      r_dest <= '0;
      r_data <= '0;
    end else begin
      r_ctrl.valid <= 1'b1;
      r_ctrl.we    <= inCtrl.we;
      r_ctrl.load  <= inCtrl.load;
      r_ctrl.ready <= inCtrl.ready | w_capture;
      r_dest       <= inDest;
      r_data       <= w_capture ? memRdata : inData;
    end
  end

  assign ctrl = r_ctrl;
  assign dest = r_dest;
  assign data = r_data;

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// +----------------------------------------------------------------------------+
// | hazard_fwd_unit: in-flight slot tracking, operand bypass and load stall.  |
// | Define HAZARD_FWD_BYPASS_EN for forwarding; otherwise a pure interlock.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_fwd_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int RADDR_W  = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic               CLK_50MHZ,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic               issue_we,
  input  logic               issue_load,
  input  logic [RADDR_W-1:0] issue_dest,
  input  logic [RADDR_W-1:0] src_a,
  input  logic [RADDR_W-1:0] src_b,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               flush,
  output logic               stall,
  output logic               fwd_a_en,
  output logic               fwd_b_en,
  output logic [DATA_W-1:0]  fwd_a_data,
  output logic [DATA_W-1:0]  fwd_b_data,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0]  wb_data
);

  if (!paramsLegal(DEPTH, LOAD_LAT)) begin : g_badParams
    $error("hazard_fwd_unit: illegal DEPTH/LOAD_LAT combination");
  end

  slotCtrl_t          w_ctrl [DEPTH];
  logic [RADDR_W-1:0] w_dest [DEPTH];
  logic [DATA_W-1:0]  w_data [DEPTH];

  slotCtrl_t          w_issueCtrl;
  logic [DATA_W-1:0]  w_issueData;
  logic               w_kill;
  logic               w_hitA;
  logic               w_hitB;
  logic               w_blockA;
  logic               w_blockB;

  assign w_issueCtrl = '{valid: issue_valid, we: issue_we, load: issue_load, ready: !issue_load};
  assign w_issueData = issue_load ? '0 : alu_result;
  assign w_kill      = flush | stall;

  // Index 0 is slot 1 (youngest); index DEPTH-1 feeds the register-file write port.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    if (k == 0) begin : g_head
      hazard_slot #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .CAPTURE (1'b0)
      ) u_slot (
        .clk      (CLK_50MHZ),
        .rst_n    (reset),
        .kill     (w_kill),
        .inCtrl   (w_issueCtrl),
        .inDest   (issue_dest),
        .inData   (w_issueData),
        .memRdata (mem_rdata),
        .ctrl     (w_ctrl[k]),
        .dest     (w_dest[k]),
        .data     (w_data[k])
      );
    end else begin : g_tail
      hazard_slot #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .CAPTURE (k == LOAD_LAT)
      ) u_slot (
        .clk      (CLK_50MHZ),
        .rst_n    (reset),
        .kill     (1'b0),
        .inCtrl   (w_ctrl[k-1]),
        .inDest   (w_dest[k-1]),
        .inData   (w_data[k-1]),
        .memRdata (mem_rdata),
        .ctrl     (w_ctrl[k]),
        .dest     (w_dest[k]),
        .data     (w_data[k])
      );
    end
  end

`ifdef HAZARD_FWD_BYPASS_EN
  logic              w_rdyA;
  logic              w_rdyB;
  logic [DATA_W-1:0] w_dataA;
  logic [DATA_W-1:0] w_dataB;

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    w_hitA  = 1'b0;
    w_hitB  = 1'b0;
    w_rdyA  = 1'b0;
    w_rdyB  = 1'b0;
    w_dataA = '0;
    w_dataB = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_ctrl[k].valid && w_ctrl[k].we && (w_dest[k] == src_a)) begin
        w_hitA  = 1'b1;
        w_rdyA  = w_ctrl[k].ready;
        w_dataA = w_data[k];
      end
      if (w_ctrl[k].valid && w_ctrl[k].we && (w_dest[k] == src_b)) begin
        w_hitB  = 1'b1;
        w_rdyB  = w_ctrl[k].ready;
        w_dataB = w_data[k];
      end
    end
  end

  assign w_blockA   = w_hitA && !w_rdyA;
  assign w_blockB   = w_hitB && !w_rdyB;
  assign fwd_a_en   = w_hitA && w_rdyA;
  assign fwd_b_en   = w_hitB && w_rdyB;
  assign fwd_a_data = fwd_a_en ? w_dataA : '0;
  assign fwd_b_data = fwd_b_en ? w_dataB : '0;
`else
  always_comb begin
    w_hitA = 1'b0;
    w_hitB = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_ctrl[k].valid && w_ctrl[k].we && (w_dest[k] == src_a)) w_hitA = 1'b1;
      if (w_ctrl[k].valid && w_ctrl[k].we && (w_dest[k] == src_b)) w_hitB = 1'b1;
    end
  end

  // Without a bypass network any in-flight producer must drain first.
  assign w_blockA   = w_hitA;
  assign w_blockB   = w_hitB;
  assign fwd_a_en   = 1'b0;
  assign fwd_b_en   = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_data = '0;
`endif

  assign stall   = issue_valid && !flush && (w_blockA || w_blockB);

  assign wb_en   = w_ctrl[DEPTH-1].valid && w_ctrl[DEPTH-1].we;
  assign wb_dest = w_dest[DEPTH-1];
  assign wb_data = wb_en ? w_data[DEPTH-1] : '0;

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
// +----------------------------------------------------------------------------+
// | tb_hazard_fwd_unit: scoreboard bench with an age-based in-flight model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_hazard_fwd_unit;

  localparam int DATA_W   = 16;
  localparam int RADDR_W  = 4;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
`ifdef HAZARD_FWD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               issue_valid, issue_we, issue_load, flush;
  logic [RADDR_W-1:0] issue_dest, src_a, src_b;
  logic [DATA_W-1:0]  alu_result, mem_rdata;
  logic               stall, fwd_a_en, fwd_b_en, wb_en;
  logic [DATA_W-1:0]  fwd_a_data, fwd_b_data, wb_data;
  logic [RADDR_W-1:0] wb_dest;

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .DATA_W   (DATA_W),
    .RADDR_W  (RADDR_W),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) dut (
    .CLK_50MHZ   (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_load  (issue_load),
    .issue_dest  (issue_dest),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_result  (alu_result),
    .mem_rdata   (mem_rdata),
    .flush       (flush),
    .stall       (stall),
    .fwd_a_en    (fwd_a_en),
    .fwd_b_en    (fwd_b_en),
    .fwd_a_data  (fwd_a_data),
    .fwd_b_data  (fwd_b_data),
    .wb_en       (wb_en),
    .wb_dest     (wb_dest),
    .wb_data     (wb_data)
  );

  // In-flight instruction: age 1 = just issued; retires after age DEPTH.
  typedef struct {
    bit          we;
    bit          isLoad;
    int          age;
    int          dest;
    logic [15:0] data;
  } instr_t;

  typedef struct {
    bit          stall;
    bit          aEn;
    logic [15:0] aData;
    bit          bEn;
    logic [15:0] bData;
    bit          wbEn;
    int          wbDest;
    logic [15:0] wbData;
  } exp_t;

  instr_t flight[$];
  exp_t   expQ[$];
  bit     rstN;
  int     compared   = 0;
  int     mismatched = 0;

  function automatic void lookup(input int src, output bit hit, output bit rdy, output logic [15:0] d);
    hit = 0; rdy = 0; d = '0;
    foreach (flight[i]) begin
      if (!hit && flight[i].we && flight[i].dest == src) begin
        hit = 1;
        rdy = !flight[i].isLoad || (flight[i].age > LOAD_LAT);
        d   = flight[i].data;
      end
    end
  endfunction

  task automatic step(input bit iv, input bit iwe, input bit ild, input int dst,
                      input int sa, input int sb, input logic [15:0] alu,
                      input logic [15:0] mem, input bit fl);
    exp_t e;
    bit hitA, rdyA, hitB, rdyB, blockA, blockB;
    logic [15:0] dA, dB;
    @(posedge clk);
    #1;
    reset       = rstN;
    issue_valid = iv;
    issue_we    = iwe;
    issue_load  = ild;
    issue_dest  = RADDR_W'(dst);
    src_a       = RADDR_W'(sa);
    src_b       = RADDR_W'(sb);
    alu_result  = alu;
    mem_rdata   = mem;
    flush       = fl;
    if (!rstN) flight.delete();
    lookup(sa, hitA, rdyA, dA);
    lookup(sb, hitB, rdyB, dB);
    if (BYPASS) begin
      e.aEn = hitA && rdyA;  e.aData = e.aEn ? dA : 16'h0;  blockA = hitA && !rdyA;
      e.bEn = hitB && rdyB;  e.bData = e.bEn ? dB : 16'h0;  blockB = hitB && !rdyB;
    end else begin
      e.aEn = 0; e.aData = 16'h0; blockA = hitA;
      e.bEn = 0; e.bData = 16'h0; blockB = hitB;
    end
    e.stall = iv && !fl && (blockA || blockB);
    e.wbEn = 0; e.wbDest = 0; e.wbData = 16'h0;
    foreach (flight[i]) begin
      if (flight[i].age == DEPTH) begin
        e.wbEn   = flight[i].we;
        e.wbDest = flight[i].dest;
        e.wbData = flight[i].we ? flight[i].data : 16'h0;
      end
    end
    expQ.push_back(e);
    if (rstN) begin
      foreach (flight[i]) begin
        if (flight[i].isLoad && flight[i].age == LOAD_LAT) flight[i].data = mem;
        flight[i].age++;
      end
      while (flight.size() > 0 && flight[$].age > DEPTH) void'(flight.pop_back());
      if (iv && !fl && !e.stall)
        flight.push_front('{we: iwe, isLoad: ild, age: 1, dest: dst, data: (ild ? 16'h0 : alu)});
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 16'h0, 16'($urandom), 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are compared half a cycle after each stimulus cycle begins.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      chk("stall",      32'(stall),      32'(e.stall));
      chk("fwd_a_en",   32'(fwd_a_en),   32'(e.aEn));
      chk("fwd_a_data", 32'(fwd_a_data), 32'(e.aData));
      chk("fwd_b_en",   32'(fwd_b_en),   32'(e.bEn));
      chk("fwd_b_data", 32'(fwd_b_data), 32'(e.bData));
      chk("wb_en",      32'(wb_en),      32'(e.wbEn));
      chk("wb_dest",    32'(wb_dest),    32'(e.wbDest));
      chk("wb_data",    32'(wb_data),    32'(e.wbData));
    end
  end

  initial begin
    reset = 0; issue_valid = 0; issue_we = 0; issue_load = 0; flush = 0;
    issue_dest = '0; src_a = '0; src_b = '0; alu_result = '0; mem_rdata = '0;

    // Reset state, with a live issue that must not stall.
    rstN = 0;
    step(1, 1, 0, 3, 3, 3, 16'h1111, 16'h0, 0);
    step(1, 1, 1, 4, 4, 4, 16'h2222, 16'h0, 0);
    rstN = 1;

    // ADD r3 then use r3.
    step(1, 1, 0, 3, 0, 0, 16'h1234, 16'h0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 1, 0, 9, 3, 8, 16'h0042, 16'h0, 0);
    for (int i = 0; i < DEPTH; i++) idle();

    // LOAD r5 followed by a consumer of r5.
    step(1, 1, 1, 5, 0, 0, 16'h0, 16'h0, 0);
    step(1, 1, 0, 6, 1, 5, 16'h0777, 16'hBEEF, 0);
    step(1, 1, 0, 6, 1, 5, 16'h0777, 16'h0000, 0);
    for (int i = 0; i < DEPTH + 1; i++) idle();

    // Two writes to r2, youngest wins.
    step(1, 1, 0, 2, 0, 0, 16'h0001, 16'h0, 0);
    step(1, 1, 0, 2, 0, 0, 16'h0002, 16'h0, 0);
    step(1, 0, 0, 0, 2, 2, 16'h0, 16'h0, 0);
    for (int i = 0; i < DEPTH + 1; i++) idle();

    // Flushed issue never lands.
    step(1, 1, 0, 7, 0, 0, 16'hDEAD, 16'h0, 1);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 7, 7, 16'h0, 16'h0, 0);

    // Reset while a load sits in slot 1.
    step(1, 1, 1, 7, 0, 0, 16'h0, 16'h0, 0);
    rstN = 0;
    step(0, 0, 0, 0, 7, 7, 16'h0, 16'h5A5A, 0);
    step(0, 0, 0, 0, 7, 7, 16'h0, 16'h5A5A, 0);
    rstN = 1;
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 7, 7, 16'h0, 16'h5A5A, 0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      rstN = ($urandom_range(0, 149) != 0);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           16'($urandom), 16'($urandom), $urandom_range(0, 9) == 0);
    end
    rstN = 1;
    idle();

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter DATA_W, default 16: register data width.
REQ-002 Parameter RADDR_W, default 4: register-select width (16 registers).
REQ-003 Parameter DEPTH, default 3, legal 2..6: in-flight slots from issue to register-file writeback.
REQ-004 Parameter LOAD_LAT, default 1, legal 1..DEPTH-1: slot index in which memory read data is valid for a load.
REQ-005 CLK_50MHZ  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 issue_valid  in  1  decoded instruction offered this cycle.
REQ-008 issue_we, issue_load  in  1 each  instruction writes a register; instruction is a memory load.
REQ-009 issue_dest, src_a, src_b  in  RADDR_W each  destination and source selects.
REQ-010 alu_result  in  DATA_W  result of the issuing non-load instruction.
REQ-011 mem_rdata  in  DATA_W  load data, valid while a load occupies slot LOAD_LAT.
REQ-012 flush  in  1  kill the youngest instruction (branch taken).
REQ-013 stall  out  1  combinational; issue refused this cycle.
REQ-014 fwd_a_en, fwd_b_en  out  1 each; fwd_a_data, fwd_b_data  out  DATA_W each  bypass values.
REQ-015 wb_en  out  1; wb_dest  out  RADDR_W; wb_data  out  DATA_W  register-file write port, driven from slot DEPTH.

Function
REQ-016 Each slot holds {valid, we, load, ready, dest, data}; slot 1 is youngest.
REQ-017 Every edge: slot k+1 <= slot k for k = 1..DEPTH-1; slot DEPTH retires.
REQ-018 Slot 1 <= issued entry when issue_valid && !stall && !flush, else a bubble (valid=0).
REQ-019 Non-load entry enters slot 1 with ready=1 and data=alu_result; load enters with ready=0.
REQ-020 A load advancing from slot LOAD_LAT into LOAD_LAT+1 captures mem_rdata and sets ready=1.
REQ-021 Source match: valid && we && dest==src; the lowest-index matching slot (youngest) wins.
REQ-022 If the winning match is ready, fwd_x_en=1 and fwd_x_data=its data; otherwise fwd_x_en=0.
REQ-023 stall=1 when issue_valid and either source's winning match is not ready; older matches are ignored.
REQ-024 A matching slot DEPTH entry is still forwarded (regfile write lands on the same edge).
REQ-025 flush invalidates slot 1 on the edge and forces the current issue to be dropped; stall is ignored while flush=1.
REQ-026 wb_en = valid && we of slot DEPTH; wb_dest, wb_data from the same slot; wb_data=0 when wb_en=0.
REQ-027 src_a==src_b both resolve independently and identically.

Reset
REQ-028 reset low clears every slot valid bit immediately, independent of the clock.
REQ-029 During reset, stall=0, fwd_*_en=0, fwd_*_data=0, wb_en=0, wb_dest=0, wb_data=0.
REQ-030 Reset asserted mid-load discards the load; no writeback occurs after release.

Configuration
REQ-031 Macro HAZARD_FWD_BYPASS_EN: when defined, forwarding behaves per REQ-021..REQ-024.
REQ-032 When undefined, fwd_*_en are tied 0, and stall=1 whenever any slot matches a source, ready or not (pure interlock).

Structure
REQ-033 Shared package cpu_pkg holds the slot-entry typedef and the DEPTH/LOAD_LAT legal-range constants.
REQ-034 One sub-module, hazard_slot, implements a single slot register with capture/advance/kill; instantiated DEPTH times.
REQ-035 Illegal parameter combinations stop elaboration.

Verification
REQ-036 Issue ADD r3 (alu_result=0x1234), next cycle issue using src_a=r3 -> fwd_a_en=1, fwd_a_data=0x1234, stall=0.
REQ-037 LOAD r5 with LOAD_LAT=1, mem_rdata=0xBEEF, next instr src_b=r5 -> stall=1 for one cycle, then fwd_b_data=0xBEEF.
REQ-038 Two writes to r2 (0x0001 then 0x0002), then read r2 -> fwd data=0x0002.
REQ-039 Issue with flush=1 -> slot 1 empty next cycle; no wb_en for that instruction DEPTH cycles later.
REQ-040 Reset low while a load sits in slot 1 -> all outputs 0 at once; after release, wb_en never asserts.
REQ-041 Build without HAZARD_FWD_BYPASS_EN, ADD r3 then use r3 -> stall=1 for DEPTH cycles, fwd_a_en=0 throughout.
